muldiv_sequencer: RTL and testbench

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_sequencer.sv | 177 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 138 +++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide unit with a fixed latency of
// XLEN calculation cycles. A multiply does one shift-add step per cycle and a
// divide does one restoring shift-subtract step per cycle, both on operand
// magnitudes. The sign is applied to the final value.
// Ports:
//   clk, reset       - clock, asynchronous active-high reset
//   start, funct3    - launch request and op select (MUL..REMU)
//   a, b             - rs1 / rs2 operands
//   flush            - aborts any in-flight operation
//   busy             - high while calculating
//   stall            - pipeline hold request (combinational)
//   done             - one-cycle pulse; result valid
//   result           - last completed result, held until the next completion
module muldiv_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN + 1);
  localparam int unsigned PW = 2 * XLEN;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d;      // product high half / partial remainder
  logic [XLEN-1:0] lo_q, lo_d;      // multiplier shifting out / dividend -> quotient
  logic [XLEN-1:0] opb_q, opb_d;    // multiplicand or divisor magnitude
  logic [XLEN-1:0] result_q, result_d;
  logic [2:0]      op_q, op_d;
  logic            a_neg_q, a_neg_d;
  logic            b_neg_q, b_neg_d;
  logic            b_zero_q, b_zero_d;

  logic            accept;
  logic            last;
  logic            signed_a, signed_b;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift, div_diff;
  logic            div_ge;
  logic [XLEN-1:0] step_hi, step_lo;
  logic [PW-1:0]   prod, prod_fix;
  logic [XLEN-1:0] quot_fix, rem_fix, res_c;

  assign accept = (state_q == IDLE) && start && !flush;
  assign last   = (cnt_q == CW'(XLEN - 1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; flush always returns to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (flush) state_d = IDLE; else if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from the state register
  always_comb begin
    busy  = (state_q == CALC);
    done  = (state_q == DONE);
    stall = accept || (state_q == CALC);
  end

  // Operand signedness: MULH/DIV/REM sign both, MULHSU signs only a
  always_comb begin
    signed_a = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    signed_b = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_mag    = (signed_a && a[XLEN-1]) ? XLEN'(XLEN'(0) - a) : a;
    b_mag    = (signed_b && b[XLEN-1]) ? XLEN'(XLEN'(0) - b) : b;
  end

  // One iteration of shift-add multiply or restoring divide
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : (XLEN + 1)'(0));
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    div_ge    = !div_diff[XLEN];
    if (op_q[2]) begin
      step_hi = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
      step_lo = {lo_q[XLEN-2:0], div_ge};
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  // Final sign correction and result selection from the last step
  always_comb begin
    prod     = {step_hi, step_lo};
    prod_fix = (a_neg_q ^ b_neg_q) ? PW'(PW'(0) - prod) : prod;
    quot_fix = (a_neg_q ^ b_neg_q) ? XLEN'(XLEN'(0) - step_lo) : step_lo;
    rem_fix  = a_neg_q ? XLEN'(XLEN'(0) - step_hi) : step_hi;
    case (op_q)
      3'b000:                 res_c = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: res_c = prod_fix[PW-1:XLEN];
      3'b100, 3'b101:         res_c = b_zero_q ? '1 : quot_fix;
      default:                res_c = rem_fix;   // a divide by zero leaves rem = a
    endcase
  end

  // Datapath next-state
  always_comb begin
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    result_d = result_q;
    op_d     = op_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    b_zero_d = b_zero_q;
    if (accept) begin
      cnt_d    = '0;
      op_d     = funct3;
      a_neg_d  = signed_a && a[XLEN-1];
      b_neg_d  = signed_b && b[XLEN-1];
      b_zero_d = (b == '0);
      hi_d     = '0;
      lo_d     = funct3[2] ? a_mag : b_mag;
      opb_d    = funct3[2] ? b_mag : a_mag;
    end else if (state_q == CALC && !flush) begin
      cnt_d = CW'(cnt_q + CW'(1));
      hi_d  = step_hi;
      lo_d  = step_lo;
      if (last) result_d = res_c;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      result_q <= '0;
      op_q     <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      b_zero_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      op_q     <= op_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      b_zero_q <= b_zero_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed testbench for muldiv_sequencer: latency, arithmetic corner cases,
// flush and asynchronous reset behaviour.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] a, b;
  logic        flush;
  logic        busy, stall, done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .a(a), .b(b), .flush(flush),
    .busy(busy), .stall(stall), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch at edge N, verify busy over N+1..N+32, done only in N+33, result hold.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] exp, input bit hold_start);
    int bad;
    @(negedge clk);
    funct3 = f; a = av; b = bv; start = 1'b1;
    #1;
    check({tag, " stall_req"}, 64'(stall), 64'd1);
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    bad = 0;
    for (int i = 1; i <= 32; i++) begin
      if (busy !== 1'b1 || done !== 1'b0 || stall !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    check({tag, " busy_window"}, 64'(bad), 64'd0);
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " busy_in_done"}, 64'(busy), 64'd0);
    check({tag, " result"}, 64'(result), 64'(exp));
    start = 1'b0;
    @(posedge clk); #1;
    check({tag, " done_clear"}, 64'(done), 64'd0);
    check({tag, " result_hold"}, 64'(result), 64'(exp));
  endtask

  initial begin
    int cnt;
    reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'b000; a = '0; b = '0;
    #12;
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst stall", 64'(stall), 64'd0);
    check("rst result", 64'(result), 64'd0);
    @(negedge clk); reset = 1'b0;

    // Arithmetic, first op straight after reset
    run_op("mul",      3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
    run_op("mulhu",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    run_op("mulh",     3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0);
    run_op("mulhsu",   3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    run_op("mulh_min", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0);
    run_op("div",      3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b1);
    run_op("rem",      3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0);
    run_op("div_nb",   3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0);
    run_op("rem_nb",   3'b110, 32'd7,        32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_op("divu_z",   3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b0);
    run_op("remu_z",   3'b111, 32'd5,        32'd0,        32'd5,        1'b0);
    run_op("div_negz", 3'b100, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1'b0);
    run_op("rem_negz", 3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1'b0);
    run_op("div_ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0);
    run_op("rem_ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0);
    run_op("remu",     3'b111, 32'd100,      32'd7,        32'd2,        1'b0);

    // Flush coincident with start: no launch
    @(negedge clk);
    funct3 = 3'b000; a = 32'd3; b = 32'd3; start = 1'b1; flush = 1'b1;
    #1;
    check("flush_start stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    check("flush_start busy", 64'(busy), 64'd0);
    start = 1'b0; flush = 1'b0;
    cnt = 0;
    repeat (36) begin @(posedge clk); #1; if (done === 1'b1) cnt++; end
    check("flush_start no_done", 64'(cnt), 64'd0);
    check("flush_start result", 64'(result), 64'd2);

    // Flush mid-calculation at cycle N+10
    @(negedge clk);
    funct3 = 3'b101; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    check("flush busy_n10", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush busy_n11", 64'(busy), 64'd0);
    check("flush done_n11", 64'(done), 64'd0);
    check("flush result_n11", 64'(result), 64'd2);
    @(posedge clk); #1;
    check("flush done_n12", 64'(done), 64'd0);
    run_op("divu_after_flush", 3'b101, 32'd100, 32'd7, 32'd14, 1'b0);

    // Asynchronous reset at cycle N+5
    @(negedge clk);
    funct3 = 3'b000; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("areset busy_before", 64'(busy), 64'd1);
    #1; reset = 1'b1; #1;
    check("areset busy", 64'(busy), 64'd0);
    check("areset result", 64'(result), 64'd0);
    check("areset done", 64'(done), 64'd0);
    check("areset stall", 64'(stall), 64'd0);
    @(negedge clk); reset = 1'b0;
    cnt = 0;
    repeat (40) begin @(posedge clk); #1; if (done === 1'b1 || busy === 1'b1) cnt++; end
    check("areset no_done", 64'(cnt), 64'd0);
    run_op("mul_after_reset", 3'b000, 32'd9, 32'd9, 32'd81, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
